// File: rtl/dds_phase_accumulator.sv
// DDFS head: pipelined W-bit phase accumulator with shadowed FTW/POW load.
// Define PA_DITHER_EN to add LFSR phase dither on the low DITHER_W bits.
module dds_phase_accumulator #(
   parameter int W        = 32,
   parameter int SPLIT    = 16,
   parameter int DITHER_W = 14
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_ftw,
   input  logic [W-1:0] cfg_pow,
   input  logic         cfg_sync,
   output logic [W-1:0] PA_out,
   output logic         pa_valid,
   output logic         wrap
);

   localparam int HI = W - SPLIT;

   if (SPLIT < 1 || SPLIT >= W || DITHER_W < 1 || DITHER_W > W) begin : g_bad_param
      $error("dds_phase_accumulator: illegal SPLIT or DITHER_W");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PEND} state_t;

   state_t         state_q;
   logic           cfg_ready_q;
   logic [W-1:0]   ftw_q, pow_q;
   logic [W-1:0]   shd_ftw_q, shd_pow_q;
   logic           shd_sync_q;

   logic           accept, fire, commit, restart;
   logic [W-1:0]   ftw_eff, pow_eff;

   logic [SPLIT-1:0] lo_acc_q, lo_base;
   logic [SPLIT:0]   lo_sum;
   logic [HI-1:0]    hi_acc_q, hi_base;
   logic [HI:0]      hi_sum;

   logic             s1_v_q, s1_c_q, s1_rst_q;
   logic [SPLIT-1:0] s1_lo_q;
   logic [HI-1:0]    s1_fhi_q;
   logic [W-1:0]     s1_pow_q;

   logic             s2_v_q, s2_wrap_q;
   logic [W-1:0]     s2_acc_q, s2_pow_q;

   logic [W-1:0]     pa_d, pa_q;
   logic             pa_valid_q, wrap_q;

`ifdef PA_DITHER_EN
   logic [31:0]         lfsr_q;
   logic [DITHER_W-1:0] s1_dth_q, s2_dth_q;
`endif

   assign accept  = cfg_valid & cfg_ready_q;
   assign fire    = en & (state_q != S_IDLE);
   assign commit  = en & (state_q == S_PEND);
   assign restart = commit & shd_sync_q;
   assign ftw_eff = commit ? shd_ftw_q : ftw_q;
   assign pow_eff = commit ? shd_pow_q : pow_q;

   // Stage 1: low segment of acc + ftw
   assign lo_base = restart ? '0 : lo_acc_q;
   assign lo_sum  = {1'b0, lo_base} + {1'b0, ftw_eff[SPLIT-1:0]};

   // Stage 2: high segment one cycle later, with the registered low carry
   assign hi_base = s1_rst_q ? '0 : hi_acc_q;
   assign hi_sum  = {1'b0, hi_base} + {1'b0, s1_fhi_q}
                  + {{HI{1'b0}}, s1_c_q};

`ifdef PA_DITHER_EN
   assign pa_d = s2_acc_q + s2_pow_q
               + {{(W-DITHER_W){1'b0}}, s2_dth_q};
`else
   assign pa_d = s2_acc_q + s2_pow_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cfg_ready_q <= 1'b1;
         ftw_q       <= '0;
         pow_q       <= '0;
         shd_ftw_q   <= '0;
         shd_pow_q   <= '0;
         shd_sync_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: if (accept) begin
               ftw_q   <= cfg_ftw;
               pow_q   <= cfg_pow;
               state_q <= S_RUN;
            end
            S_RUN: if (accept) begin
               shd_ftw_q   <= cfg_ftw;
               shd_pow_q   <= cfg_pow;
               shd_sync_q  <= cfg_sync;
               cfg_ready_q <= 1'b0;
               state_q     <= S_PEND;
            end
            S_PEND: if (en) begin
               ftw_q       <= shd_ftw_q;
               pow_q       <= shd_pow_q;
               cfg_ready_q <= 1'b1;
               state_q     <= S_RUN;
            end
            default: begin
               cfg_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lo_acc_q   <= '0;
         hi_acc_q   <= '0;
         s1_v_q     <= 1'b0;
         s1_c_q     <= 1'b0;
         s1_rst_q   <= 1'b0;
         s1_lo_q    <= '0;
         s1_fhi_q   <= '0;
         s1_pow_q   <= '0;
         s2_v_q     <= 1'b0;
         s2_wrap_q  <= 1'b0;
         s2_acc_q   <= '0;
         s2_pow_q   <= '0;
         pa_q       <= '0;
         pa_valid_q <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         // IDLE has nothing in flight, so both halves can be cleared at once
         if (state_q == S_IDLE && accept) begin
            lo_acc_q <= '0;
            hi_acc_q <= '0;
         end else begin
            if (fire)   lo_acc_q <= lo_sum[SPLIT-1:0];
            if (s1_v_q) hi_acc_q <= hi_sum[HI-1:0];
         end
         s1_v_q <= fire;
         if (fire) begin
            s1_lo_q  <= lo_base;
            s1_c_q   <= lo_sum[SPLIT];
            s1_fhi_q <= ftw_eff[W-1:SPLIT];
            s1_pow_q <= pow_eff;
            s1_rst_q <= restart;
         end
         s2_v_q <= s1_v_q;
         if (s1_v_q) begin
            s2_acc_q  <= {hi_base, s1_lo_q};
            s2_wrap_q <= hi_sum[HI];
            s2_pow_q  <= s1_pow_q;
         end
         pa_valid_q <= s2_v_q;
         wrap_q     <= s2_v_q & s2_wrap_q;
         if (s2_v_q) pa_q <= pa_d;
      end
   end

`ifdef PA_DITHER_EN
   // Galois form of x^32+x^22+x^2+x+1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q   <= 32'hACE1_0001;
         s1_dth_q <= '0;
         s2_dth_q <= '0;
      end else begin
         if (fire) begin
            lfsr_q   <= {1'b0, lfsr_q[31:1]}
                      ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
            s1_dth_q <= lfsr_q[DITHER_W-1:0];
         end
         if (s1_v_q) s2_dth_q <= s1_dth_q;
      end
   end
`endif

   assign cfg_ready = cfg_ready_q;
   assign PA_out    = pa_q;
   assign pa_valid  = pa_valid_q;
   assign wrap      = wrap_q;

endmodule
